// File: rtl/insn_aligner_pkg.sv
// Shared types for the fetch-to-decode path: buffer entries, trap info,
// aligner state and the aligned instruction record that decode imports.
package insn_aligner_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int HALF_WIDTH = 16;
    localparam int INSN_WIDTH = 32;
    localparam int CODE_WIDTH = 4;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    localparam logic [CODE_WIDTH-1:0] EXCEPTION_CODE_INSN_ACCESS_FAULT = 4'd1;
    localparam logic [CODE_WIDTH-1:0] EXCEPTION_CODE_ILLEGAL_INSN      = 4'd2;

    typedef struct packed {
        addr_t                  pc;
        logic [HALF_WIDTH-1:0]  insn;
        logic                   fault;
        logic                   interruptValid;
        logic [CODE_WIDTH-1:0]  interruptCode;
    } InsnBufferEntry;

    typedef struct packed {
        logic                   valid;
        logic                   isInterrupt;
        logic [CODE_WIDTH-1:0]  code;
        logic [ADDR_WIDTH-1:0]  value;
    } TrapInfo;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } AlignerState;

    typedef struct packed {
        addr_t                  pc;
        logic [INSN_WIDTH-1:0]  insn;
        logic                   compressed;
        TrapInfo                trap;
    } AlignedInsn;

    // Any halfword whose two low bits are not 2'b11 is a complete RVC instruction.
    function automatic logic is_compressed(input logic [HALF_WIDTH-1:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/insn_aligner.sv
// Instruction aligner: turns the 16-bit halfword stream from the instruction
// buffer into whole instructions (RVC or 32-bit) with a registered output
// to decode, carrying pc, compressed flag and fetch-fault/interrupt traps.
//
// Build option RAFI_ALIGNER_RVC_EN: when defined, compressed halfwords are
// emitted as instructions; when undefined they raise an illegal-instruction
// trap. Upper halves of 32-bit instructions are never classified.
//
// state | meaning
// EMPTY | no halfword held; next accepted entry starts an instruction
// HELD  | low half of a 32-bit instruction held, waiting for pc+2
module insn_aligner
    import insn_aligner_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  flush,
    input  logic                  inValid,
    output logic                  inReady,
    input  InsnBufferEntry        inEntry,
    output logic                  outValid,
    input  logic                  outReady,
    output addr_t                 outPc,
    output logic [INSN_WIDTH-1:0] outInsn,
    output logic                  outCompressed,
    output TrapInfo               outTrap
);

    AlignerState           state_q, state_d;
    addr_t                 held_pc_q, held_pc_d;
    logic [HALF_WIDTH-1:0] held_insn_q, held_insn_d;
    AlignedInsn            out_q, out_d;
    logic                  out_valid_q, out_valid_d;

    logic  in_fire;
    addr_t held_pc_next;

    // Accept only when the output slot is free or being drained this cycle.
    assign inReady      = !flush && (!out_valid_q || outReady);
    assign in_fire      = inValid && inReady;
    assign held_pc_next = held_pc_q + addr_t'(2);

    // Next-state and next-output selection; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        held_pc_d   = held_pc_q;
        held_insn_d = held_insn_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !outReady;

        if (flush) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
        end else if (in_fire) begin
            if (state_q == HELD && inEntry.interruptValid) begin
                // Interrupt is reported at the pc of the abandoned instruction.
                out_d                  = '0;
                out_d.pc               = held_pc_q;
                out_d.trap.valid       = 1'b1;
                out_d.trap.isInterrupt = 1'b1;
                out_d.trap.code        = inEntry.interruptCode;
                out_valid_d            = 1'b1;
                state_d                = EMPTY;
            end else if (state_q == HELD && inEntry.pc == held_pc_next) begin
                out_d       = '0;
                out_d.pc    = held_pc_q;
                out_valid_d = 1'b1;
                state_d     = EMPTY;
                if (inEntry.fault) begin
                    // Fault address is the upper half that failed to fetch.
                    out_d.trap.valid = 1'b1;
                    out_d.trap.code  = EXCEPTION_CODE_INSN_ACCESS_FAULT;
                    out_d.trap.value = held_pc_next;
                end else begin
                    out_d.insn = {inEntry.insn, held_insn_q};
                end
            end else begin
                // EMPTY, or a discontinuity in HELD: the held half is dropped
                // and this entry starts a fresh instruction.
                state_d = EMPTY;
                out_d   = '0;
                out_d.pc = inEntry.pc;
                if (inEntry.interruptValid) begin
                    out_d.trap.valid       = 1'b1;
                    out_d.trap.isInterrupt = 1'b1;
                    out_d.trap.code        = inEntry.interruptCode;
                    out_valid_d            = 1'b1;
                end else if (inEntry.fault) begin
                    out_d.trap.valid = 1'b1;
                    out_d.trap.code  = EXCEPTION_CODE_INSN_ACCESS_FAULT;
                    out_d.trap.value = inEntry.pc;
                    out_valid_d      = 1'b1;
                end else if (is_compressed(inEntry.insn)) begin
`ifdef RAFI_ALIGNER_RVC_EN
                    out_d.insn       = {{(INSN_WIDTH-HALF_WIDTH){1'b0}}, inEntry.insn};
                    out_d.compressed = 1'b1;
`else
                    out_d.trap.valid = 1'b1;
                    out_d.trap.code  = EXCEPTION_CODE_ILLEGAL_INSN;
                    out_d.trap.value = {{(ADDR_WIDTH-HALF_WIDTH){1'b0}}, inEntry.insn};
`endif
                    out_valid_d = 1'b1;
                end else begin
                    // Low half of a 32-bit instruction; restore the previous
                    // output contents since nothing is emitted.
                    out_d       = out_q;
                    held_pc_d   = inEntry.pc;
                    held_insn_d = inEntry.insn;
                    state_d     = HELD;
                end
            end
        end
    end

    // State, held halfword and output register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= EMPTY;
            held_pc_q   <= '0;
            held_insn_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_pc_q   <= held_pc_d;
            held_insn_q <= held_insn_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outValid      = out_valid_q;
    assign outPc         = out_q.pc;
    assign outInsn       = out_q.insn;
    assign outCompressed = out_q.compressed;
    assign outTrap       = out_q.trap;

endmodule
